// File: rtl/mux_rr_nch.sv
// N-channel to 1 interleaving mux: per-channel FIFOs feeding one registered output,
// served by work-conserving round-robin (mode=1) or fixed TDM slots (mode=0).
// Optional per-channel saturating drop counters are built when MUX_DROP_CNT_EN is defined.
module mux_rr_nch #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS*WIDTH-1:0]     data_in,
  input  logic [CHANNELS-1:0]           valid_in,
  output logic [CHANNELS-1:0]           ready_out,
  input  logic                          mode,
  input  logic                          ready_in,
  output logic [WIDTH-1:0]              data_out,
  output logic                          valid_out,
  output logic [$clog2(CHANNELS)-1:0]   chan_out
`ifdef MUX_DROP_CNT_EN
  ,
  output logic [CHANNELS*8-1:0]         drop_cnt
`endif
);

  localparam int unsigned CW = $clog2(CHANNELS);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0]    mem_q [CHANNELS][DEPTH];
  logic [WIDTH-1:0]    mem_d [CHANNELS][DEPTH];
  logic [AW:0]         wr_ptr_q [CHANNELS];
  logic [AW:0]         wr_ptr_d [CHANNELS];
  logic [AW:0]         rd_ptr_q [CHANNELS];
  logic [AW:0]         rd_ptr_d [CHANNELS];

  logic [CHANNELS-1:0] full, empty, push, pop;
  logic [CW-1:0]       ptr_q, ptr_d, gnt_idx, scan_idx;
  logic                gnt_found, load;

  logic [WIDTH-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic [CW-1:0]       chan_q, chan_d;

  // Pointers carry one extra wrap bit: equal means empty, MSB-only difference means full.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
    end
  end

  assign ready_out = ~full;
  assign push      = valid_in & ~full;

  // Reverse scan so the last hit is the first non-empty channel at or after ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    scan_idx  = ptr_q;
    if (mode) begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        scan_idx = ptr_q + CW'(k);
        if (!empty[scan_idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = scan_idx;
        end
      end
    end else begin
      gnt_found = !empty[ptr_q];
    end
  end

  always_comb begin
    load    = !valid_q || ready_in;
    pop     = '0;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = gnt_found;
      if (gnt_found) begin
        pop[gnt_idx] = 1'b1;
        data_d       = mem_q[gnt_idx][rd_ptr_q[gnt_idx][AW-1:0]];
        chan_d       = gnt_idx;
      end else if (!mode) begin
        chan_d = ptr_q;
      end
      if (!mode) begin
        ptr_d = ptr_q + CW'(1);
      end else if (gnt_found) begin
        ptr_d = gnt_idx + CW'(1);
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i][AW-1:0]] = data_in[i*WIDTH +: WIDTH];
      end
      wr_ptr_d[i] = wr_ptr_q[i] + (AW+1)'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + (AW+1)'(pop[i]);
    end
  end

  // Storage needs no reset: emptiness is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign chan_out  = chan_q;

`ifdef MUX_DROP_CNT_EN
  logic [7:0] drop_q [CHANNELS];
  logic [7:0] drop_d [CHANNELS];

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      drop_d[i] = drop_q[i];
      if (valid_in[i] && full[i] && (drop_q[i] != 8'hFF)) begin
        drop_d[i] = drop_q[i] + 8'd1;
      end
      drop_cnt[i*8 +: 8] = drop_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        drop_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        drop_q[i] <= drop_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux_rr_nch.sv
// Bench for mux_rr_nch (4 channels x 8 bits, depth 4): TDM table vectors, a scoreboard
// for every output handshake, and hand-written overflow, stall and reset sequences.
module tb_mux_rr_nch;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned DEPTH    = 4;

  logic                      clk;
  logic                      reset;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [CHANNELS-1:0]       valid_in;
  logic [CHANNELS-1:0]       ready_out;
  logic                      mode;
  logic                      ready_in;
  logic [WIDTH-1:0]          data_out;
  logic                      valid_out;
  logic [1:0]                chan_out;
`ifdef MUX_DROP_CNT_EN
  logic [CHANNELS*8-1:0]     drop_cnt;
`endif

  mux_rr_nch #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .mode      (mode),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .chan_out  (chan_out)
`ifdef MUX_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] chan;
  } sb_t;

  typedef struct {
    logic [3:0]  vin;
    logic [31:0] din;
    logic        md;
    logic        exp_v;
    logic [1:0]  exp_c;
    logic [7:0]  exp_d;
  } vec_t;

  sb_t  sb[$];
  vec_t tdm_vec[8];
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: compare any output handshake against the scoreboard, then advance.
  task automatic step();
    sb_t exp;
    @(negedge clk);
    if (valid_out && ready_in) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got data %0h chan %0d expected no output",
                 data_out, chan_out);
      end else begin
        exp = sb.pop_front();
        chk("sb_data", 32'(data_out), 32'(exp.data));
        chk("sb_chan", 32'(chan_out), 32'(exp.chan));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_sb(input logic [7:0] d, input logic [1:0] c);
    sb_t e;
    e.data = d;
    e.chan = c;
    sb.push_back(e);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    mode     = 1'b1;
    ready_in = 1'b1;
    valid_in = '0;
    data_in  = '0;

    // TDM rotation with only ch1 holding data, starting from ptr=0.
    tdm_vec[0] = '{vin: 4'b0010, din: 32'h0000_2100, md: 1'b0, exp_v: 1'b0, exp_c: 2'd0, exp_d: 8'h00};
    tdm_vec[1] = '{vin: 4'b0010, din: 32'h0000_2200, md: 1'b0, exp_v: 1'b1, exp_c: 2'd1, exp_d: 8'h21};
    tdm_vec[2] = '{vin: 4'b0000, din: 32'h0,         md: 1'b0, exp_v: 1'b0, exp_c: 2'd2, exp_d: 8'h00};
    tdm_vec[3] = '{vin: 4'b0000, din: 32'h0,         md: 1'b0, exp_v: 1'b0, exp_c: 2'd3, exp_d: 8'h00};
    tdm_vec[4] = '{vin: 4'b0000, din: 32'h0,         md: 1'b0, exp_v: 1'b0, exp_c: 2'd0, exp_d: 8'h00};
    tdm_vec[5] = '{vin: 4'b0000, din: 32'h0,         md: 1'b0, exp_v: 1'b1, exp_c: 2'd1, exp_d: 8'h22};
    tdm_vec[6] = '{vin: 4'b0000, din: 32'h0,         md: 1'b0, exp_v: 1'b0, exp_c: 2'd2, exp_d: 8'h00};
    tdm_vec[7] = '{vin: 4'b0000, din: 32'h0,         md: 1'b0, exp_v: 1'b0, exp_c: 2'd3, exp_d: 8'h00};

    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_chan", 32'(chan_out), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'hF);
`ifdef MUX_DROP_CNT_EN
    chk("rst_drop", drop_cnt, 32'd0);
`endif
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // Single push to ch2 in round-robin: one cycle of visible latency.
    valid_in = 4'b0100;
    data_in[2*8 +: 8] = 8'hA5;
    push_sb(8'hA5, 2'd2);
    step();
    valid_in = '0;
    data_in  = '0;
    step();
    chk("single_valid", 32'(valid_out), 32'd1);
    chk("single_data", 32'(data_out), 32'hA5);
    chk("single_chan", 32'(chan_out), 32'd2);
    step();
    chk("single_idle", 32'(valid_out), 32'd0);

    // All four channels in one cycle drain in order 0..3.
    do_reset();
    valid_in = 4'b1111;
    data_in  = 32'h1312_1110;
    for (int c = 0; c < 4; c++) push_sb(8'(8'h10 + c), 2'(c));
    step();
    valid_in = '0;
    data_in  = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rr_valid", 32'(valid_out), 32'd1);
      chk("rr_chan", 32'(chan_out), 32'(c));
    end
    step();
    chk("rr_idle", 32'(valid_out), 32'd0);

    // TDM table; relies on ptr having wrapped back to 0 above.
    for (int r = 0; r < 8; r++) begin
      mode     = tdm_vec[r].md;
      valid_in = tdm_vec[r].vin;
      data_in  = tdm_vec[r].din;
      for (int c = 0; c < 4; c++) begin
        if (tdm_vec[r].vin[c]) push_sb(tdm_vec[r].din[c*8 +: 8], 2'(c));
      end
      step();
      chk("tdm_valid", 32'(valid_out), 32'(tdm_vec[r].exp_v));
      chk("tdm_chan", 32'(chan_out), 32'(tdm_vec[r].exp_c));
      if (tdm_vec[r].exp_v) chk("tdm_data", 32'(data_out), 32'(tdm_vec[r].exp_d));
    end
    valid_in = '0;
    data_in  = '0;

    // Stall output on a ch3 word, then overfill ch0.
    mode     = 1'b1;
    ready_in = 1'b0;
    valid_in = 4'b1000;
    data_in[3*8 +: 8] = 8'h33;
    push_sb(8'h33, 2'd3);
    step();
    valid_in = '0;
    data_in  = '0;
    step();
    chk("stall_load_valid", 32'(valid_out), 32'd1);
    chk("stall_load_chan", 32'(chan_out), 32'd3);
    for (int k = 0; k < 6; k++) begin
      valid_in = 4'b0001;
      data_in[7:0] = 8'(8'h40 + k);
      if (k < 4) push_sb(8'(8'h40 + k), 2'd0);
      step();
      chk("ovf_ready0", 32'(ready_out[0]), (k < 3) ? 32'd1 : 32'd0);
    end
    valid_in = '0;
    data_in  = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_valid", 32'(valid_out), 32'd1);
      chk("hold_data", 32'(data_out), 32'h33);
      chk("hold_chan", 32'(chan_out), 32'd3);
      chk("hold_ready", 32'(ready_out), 32'hE);
    end
`ifdef MUX_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, 32'h0000_0002);
`endif
    ready_in = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("drain_idle", 32'(valid_out), 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset with words buffered and output valid.
    ready_in = 1'b0;
    valid_in = 4'b1111;
    data_in  = 32'h5352_5150;
    step();
    valid_in = '0;
    data_in  = '0;
    step();
    chk("pre_rst_valid", 32'(valid_out), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(valid_out), 32'd0);
    chk("async_rst_data", 32'(data_out), 32'd0);
    chk("async_rst_ready", 32'(ready_out), 32'hF);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_idle", 32'(valid_out), 32'd0);
    end
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_nch.md
# mux_rr_nch

Parametrised N-channel to 1 interleaving multiplexer. It is the successor of the two-channel 8-bit mux. Each input channel has its own small FIFO. One shared output register is served either by work-conserving round-robin or by fixed TDM slots, with valid/ready backpressure on the output. The whole block runs on a single clock; clock-enable style slotting replaces the divided clkf/clk2f/clk4f domains.

## Interface
- WIDTH, 8, data width per channel
- CHANNELS, 4, number of input channels; power of two, 2..8
- DEPTH, 4, entries per channel FIFO; power of two, 2..16
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset; low clears all state immediately
- data_in  in  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- valid_in  in  CHANNELS  per-channel write strobe
- ready_out  out  CHANNELS  per-channel not-full flag (combinational from FIFO state)
- mode  in  1  0 = fixed TDM slot, 1 = work-conserving round-robin
- ready_in  in  1  downstream can accept data_out this cycle
- data_out  out  WIDTH  registered output word
- valid_out  out  1  data_out/chan_out valid
- chan_out  out  log2(CHANNELS)  source channel of data_out
- drop_cnt  out  CHANNELS*8  per-channel saturating overflow counters (only with MUX_DROP_CNT_EN)

## Operation
- Reset state:
  - all FIFOs empty, so ready_out is all ones;
  - data_out = 0, valid_out = 0, chan_out = 0;
  - slot pointer ptr = 0;
  - drop_cnt = 0.
- Push: channel i writes when valid_in[i] && ready_out[i]. valid_in[i] while full is discarded. Full is evaluated on pre-edge state, so a same-cycle pop does not rescue a push into a full FIFO.
- Load opportunity L = !valid_out || ready_in. Outside L, data_out, valid_out and chan_out hold stable and nothing is popped.
- Mode 1 (round-robin):
  - at L, grant the first non-empty channel scanning ptr, ptr+1, … modulo CHANNELS;
  - pop it and load data_out, chan_out and valid_out = 1;
  - then set ptr = grant+1 mod CHANNELS;
  - if all channels are empty, valid_out = 0 and ptr is unchanged.
- Mode 0 (TDM):
  - at L, serve channel ptr only;
  - if it is non-empty, pop and load with valid_out = 1;
  - otherwise valid_out = 0 and chan_out = ptr;
  - ptr = ptr+1 mod CHANNELS on every L, whether or not the slot was used.
- mode is sampled only at L. Changing it does not reset ptr or the FIFOs.
- FIFO pointers are log2(DEPTH)+1 bits. Full and empty are decided by MSB-differs/equal. Wrap-around is natural modulo.

## Timing
- Latency: valid_in on an empty system at edge n is written at edge n. The word appears on data_out/valid_out after edge n+1 (1 cycle visible latency), provided L holds and the channel is granted.
- Throughput: 1 word/cycle with ready_in held high in mode 1. In mode 0 it is 1 slot per cycle.
- ready_out[i] drops in the cycle after the DEPTH-th accepted push, and rises in the cycle after a pop from a full FIFO.
- Reset asserted mid-transfer drops all buffered words and forces valid_out low asynchronously. Release is synchronous to the next rising edge.

## Configuration
- MUX_DROP_CNT_EN defined:
  - drop_cnt[i*8 +: 8] increments on each cycle with valid_in[i] && !ready_out[i];
  - it saturates at 255 and is cleared only by reset.
- Undefined: the drop_cnt port and its logic are absent. Drops are silent.

## Test plan
- Reset then mode=1, ready_in=1, single push ch2=8'hA5 -> next cycle valid_out=1, data_out=8'hA5, chan_out=2. Then valid_out=0.
- mode=1, all four channels pushed once in the same cycle (8'h10..8'h13) -> outputs ch0,ch1,ch2,ch3 on consecutive cycles, then ptr=0.
- mode=0, only ch1 holds data -> valid_out pattern 0,1,0,0 per 4-cycle rotation starting at ptr=0, chan_out 0,1,2,3.
- ch0 pushed 6 times back-to-back with ready_in=0, DEPTH=4 -> ready_out[0]=0 after 4th push. Words 5–6 are dropped, and drop_cnt[7:0]=2 when MUX_DROP_CNT_EN is defined. Then raising ready_in drains exactly 4 words in order.
- ready_in=0 while valid_out=1 -> data_out/chan_out stable for 5 cycles, with no FIFO pop.
- Reset pulled low with 3 words buffered and valid_out=1 -> valid_out=0 immediately, ready_out all ones, no stale word after release.
